pad_encoder: RTL and testbench

Player-input front end for the arrow game. Synchronizes and debounces the four push buttons (Up, Down, Left, Right) and groups near-simultaneous presses into one chord. It then emits a single-cycle event carrying the 5-bit arrow code used by the arrow, collision and display paths. It is the producer end of the arrow-code interface: the arrow generator pushes codes toward the player, and this block turns player presses back into the same codes for hit checking.

---
 rtl/pad_encoder_pkg.sv | 50 +++++
 rtl/pad_encoder_debounce.sv | 44 ++++
 rtl/pad_encoder.sv | 119 +++++++++++
 tb/tb_pad_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_encoder_pkg.sv
// Shared arrow-code constants and helpers for the arrow game.
// The arrow, collision and display paths use the same code values.
package pad_encoder_pkg;

  typedef enum logic [4:0] {
    CODE_BEGIN       = 5'd0,
    CODE_UP          = 5'd10,
    CODE_DOWN        = 5'd11,
    CODE_LEFT        = 5'd12,
    CODE_RIGHT       = 5'd13,
    CODE_UP_DOWN     = 5'd14,
    CODE_UP_LEFT     = 5'd15,
    CODE_UP_RIGHT    = 5'd16,
    CODE_DOWN_LEFT   = 5'd17,
    CODE_DOWN_RIGHT  = 5'd18,
    CODE_LEFT_RIGHT  = 5'd19,
    CODE_NO          = 5'd20
  } arrow_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } pad_state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  // Mask bit order is {Up, Down, Left, Right}.
  function automatic arrow_code_e mask_to_code(input logic [3:0] m);
    arrow_code_e code;
    code = CODE_BEGIN;
    case (m)
      4'b1000: code = CODE_UP;
      4'b0100: code = CODE_DOWN;
      4'b0010: code = CODE_LEFT;
      4'b0001: code = CODE_RIGHT;
      4'b1100: code = CODE_UP_DOWN;
      4'b1010: code = CODE_UP_LEFT;
      4'b1001: code = CODE_UP_RIGHT;
      4'b0110: code = CODE_DOWN_LEFT;
      4'b0101: code = CODE_DOWN_RIGHT;
      4'b0011: code = CODE_LEFT_RIGHT;
      default: code = (popcount4(m) >= 3'd3) ? CODE_NO : CODE_BEGIN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pad_encoder_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one push button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module pad_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/pad_encoder.sv
// Player-input front end: debounces four buttons, groups near-simultaneous
// presses into one chord and emits a one-cycle arrow-code event.
module pad_encoder
  import pad_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_CYCLES    = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       enable,
  output logic [3:0] held,
  output logic       press_valid,
  output logic [4:0] press_code,
  output logic       chord_error
);

  localparam int CCW = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
  localparam logic [CCW-1:0] CHORD_LAST = CCW'(CHORD_CYCLES - 1);

  logic [3:0]     raw;
  logic [3:0]     held_db;
  logic [3:0]     held_prev_reg;
  logic [3:0]     rises;

  pad_state_e     state_reg, state_next;
  logic [3:0]     mask_reg, mask_next;
  logic [CCW-1:0] cnt_reg, cnt_next;
  logic           valid_reg, valid_next;
  logic           err_reg, err_next;
  logic [4:0]     code_reg, code_next;

  assign raw = {Up, Down, Left, Right};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      pad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (raw[gi]),
        .level  (held_db[gi])
      );
    end
  endgenerate

  assign rises = held_db & ~held_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_prev_reg <= '0;
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      cnt_reg       <= '0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      code_reg      <= '0;
    end else begin
      held_prev_reg <= held_db;
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      cnt_reg       <= cnt_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
      code_reg      <= code_next;
    end
  end

  // Event outputs are registered on the COLLECT->EMIT transition, so they are
  // high exactly during the EMIT cycle.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    cnt_next   = cnt_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    code_next  = code_reg;
    case (state_reg)
      ST_IDLE, ST_EMIT: begin
        if (enable && (rises != 4'b0000)) begin
          mask_next  = rises;
          cnt_next   = '0;
          state_next = ST_COLLECT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          mask_next  = '0;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          mask_next = mask_reg | rises;
          if (cnt_reg == CHORD_LAST) begin
            state_next = ST_EMIT;
            valid_next = 1'b1;
            code_next  = mask_to_code(mask_next);
            err_next   = (popcount4(mask_next) >= 3'd3);
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign held        = held_db;
  assign press_valid = valid_reg;
  assign press_code  = code_reg;
  assign chord_error = err_reg;

endmodule

// File: tb/tb_pad_encoder.sv
// Self-checking bench for pad_encoder: code-map table, directed corner cases
// and random button activity checked against a window-based reference model.
module tb_pad_encoder;

  localparam int DEB = 4;
  localparam int CH  = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       up_b, down_b, left_b, right_b, enable;
  logic [3:0] held;
  logic       press_valid;
  logic [4:0] press_code;
  logic       chord_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pad_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CHORD_CYCLES   (CH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Up         (up_b),
    .Down       (down_b),
    .Left       (left_b),
    .Right      (right_b),
    .enable     (enable),
    .held       (held),
    .press_valid(press_valid),
    .press_code (press_code),
    .chord_error(chord_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons indexed 0..3 = Up, Down, Left, Right; vector bit 3-b holds button b.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_prev = '0, m_mask = '0;
  int         m_run[4];
  bit         m_pending = 0;
  int         m_start = 0;
  int         m_edge = 0;
  logic       m_valid = 1'b0, m_err = 1'b0;
  logic [4:0] m_code = '0;

  function automatic logic [4:0] ref_code(input logic [3:0] m);
    int n, k;
    n = $countones(m);
    if (n >= 3) return 5'd20;
    if (n == 1) begin
      for (int b = 0; b < 4; b++) if (m[3-b]) return 5'(10 + b);
    end
    if (n == 2) begin
      k = 0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++) begin
          if (m[3-i] && m[3-j]) return 5'(14 + k);
          k++;
        end
    end
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0; m_mask = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_pending = 0; m_start = 0; m_edge = 0;
    m_valid = 1'b0; m_err = 1'b0; m_code = '0;
  endtask

  task automatic model_step();
    logic [3:0] rises;
    rises   = m_db & ~m_prev;
    m_valid = 1'b0;
    m_err   = 1'b0;
    // A window opened at edge s collects through edge s+CH and emits there.
    if (m_pending) begin
      if (!enable) m_pending = 0;
      else begin
        m_mask = m_mask | rises;
        if (m_edge == m_start + CH) begin
          m_pending = 0;
          m_valid   = 1'b1;
          m_code    = ref_code(m_mask);
          m_err     = ($countones(m_mask) >= 3);
        end
      end
    end else if (enable && rises != 4'b0000) begin
      m_pending = 1;
      m_start   = m_edge;
      m_mask    = rises;
    end
    m_prev = m_db;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_db[b]  = ~m_db[b];
          m_run[b] = 0;
        end
      end else m_run[b] = 0;
    end
    m_s2 = m_s1;
    m_s1 = {up_b, down_b, left_b, right_b};
    m_edge++;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
  end

  // Cycle-by-cycle scoreboard against the model.
  initial forever begin
    @(negedge clk);
    cyc++;
    check("held", 32'(held), 32'(m_db));
    check("press_valid", 32'(press_valid), 32'(m_valid));
    check("press_code", 32'(press_code), 32'(m_code));
    check("chord_error", 32'(chord_error), 32'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_buttons(input logic [3:0] b);
    {up_b, down_b, left_b, right_b} = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         w_cnt;
  int         w_at[8];
  logic [4:0] w_code[8];
  logic       w_err[8];

  task automatic watch(input int n);
    w_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (press_valid) begin
        if (w_cnt < 8) begin
          w_at[w_cnt]   = i;
          w_code[w_cnt] = press_code;
          w_err[w_cnt]  = chord_error;
        end
        w_cnt++;
      end
    end
  endtask

  typedef struct {
    logic [3:0] buttons;
    logic [4:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int lat, hi;
    vecs[0]  = '{4'b1000, 5'd10, 1'b0};
    vecs[1]  = '{4'b0100, 5'd11, 1'b0};
    vecs[2]  = '{4'b0010, 5'd12, 1'b0};
    vecs[3]  = '{4'b0001, 5'd13, 1'b0};
    vecs[4]  = '{4'b1100, 5'd14, 1'b0};
    vecs[5]  = '{4'b1010, 5'd15, 1'b0};
    vecs[6]  = '{4'b1001, 5'd16, 1'b0};
    vecs[7]  = '{4'b0110, 5'd17, 1'b0};
    vecs[8]  = '{4'b0101, 5'd18, 1'b0};
    vecs[9]  = '{4'b0011, 5'd19, 1'b0};
    vecs[10] = '{4'b1110, 5'd20, 1'b1};
    vecs[11] = '{4'b1101, 5'd20, 1'b1};
    vecs[12] = '{4'b1011, 5'd20, 1'b1};
    vecs[13] = '{4'b0111, 5'd20, 1'b1};
    vecs[14] = '{4'b1111, 5'd20, 1'b1};

    reset_n = 1'b0;
    enable  = 1'b1;
    set_buttons(4'b0000);
    tick(3);
    check("reset_held", 32'(held), 0);
    check("reset_valid", 32'(press_valid), 0);
    check("reset_code", 32'(press_code), 0);
    check("reset_err", 32'(chord_error), 0);
    #2 reset_n = 1'b1;
    tick(2);

    // Code map table.
    foreach (vecs[v]) begin
      set_buttons(vecs[v].buttons);
      watch(30);
      check("table_count", w_cnt, 1);
      if (w_cnt >= 1) begin
        check("table_code", 32'(w_code[0]), 32'(vecs[v].code));
        check("table_err", 32'(w_err[0]), 32'(vecs[v].err));
        $display("vec %0d buttons=%b code=%0d err=%0d", v, vecs[v].buttons, w_code[0], w_err[0]);
      end
      set_buttons(4'b0000);
      tick(16);
    end

    // Clean single press: latency raw->held and rise->valid.
    set_buttons(4'b1000);
    lat = 0;
    do begin tick(1); lat++; end while (!held[3] && lat < 20);
    check("raw_to_held", lat, 2 + DEB);
    lat = 0;
    do begin tick(1); lat++; end while (!press_valid && lat < 30);
    check("rise_to_valid", lat, 1 + CH);
    check("single_code", 32'(press_code), 10);
    check("single_err", 32'(chord_error), 0);
    watch(25);
    check("single_extra", w_cnt, 0);
    $display("single press latency checked, code=%0d", press_code);
    set_buttons(4'b0000);
    tick(16);

    // Bounce: 2-cycle pulses never qualify.
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      up_b = ((i / 2) % 2) == 0;
      tick(1);
      if (held[3]) hi++;
    end
    up_b = 1'b0;
    watch(20);
    check("bounce_held", hi, 0);
    check("bounce_events", w_cnt, 0);
    $display("bounce sequence done");

    // Up then Left 5 cycles later.
    set_buttons(4'b1000);
    tick(5);
    set_buttons(4'b1010);
    watch(40);
    check("chord_count", w_cnt, 1);
    if (w_cnt >= 1) check("chord_code", 32'(w_code[0]), 15);
    $display("two-button chord events=%0d", w_cnt);
    set_buttons(4'b0000);
    tick(16);

    // Up, Down, Right staggered inside one window.
    set_buttons(4'b1000);
    tick(2);
    set_buttons(4'b1100);
    tick(2);
    set_buttons(4'b1101);
    watch(30);
    check("illegal_count", w_cnt, 1);
    if (w_cnt >= 1) begin
      check("illegal_code", 32'(w_code[0]), 20);
      check("illegal_err", 32'(w_err[0]), 1);
    end
    $display("illegal chord events=%0d", w_cnt);
    set_buttons(4'b0000);
    tick(16);

    // Enable drop mid-window.
    set_buttons(4'b0001);
    tick(2 + DEB + 3);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    watch(30);
    check("enable_abort", w_cnt, 0);
    $display("enable abort events=%0d", w_cnt);
    set_buttons(4'b0000);
    tick(16);

    // Reset mid-window.
    set_buttons(4'b0100);
    tick(2 + DEB + 3);
    #2 reset_n = 1'b0;
    #1;
    check("abort_held", 32'(held), 0);
    check("abort_valid", 32'(press_valid), 0);
    check("abort_code", 32'(press_code), 0);
    check("abort_err", 32'(chord_error), 0);
    set_buttons(4'b0000);
    tick(3);
    #2 reset_n = 1'b1;
    watch(30);
    check("reset_abort", w_cnt, 0);
    $display("reset abort events=%0d", w_cnt);

    // Back-to-back: Right rises in the EMIT cycle of a Down event.
    set_buttons(4'b0100);
    tick(1 + CH);
    set_buttons(4'b0101);
    watch(30);
    check("b2b_count", w_cnt, 2);
    if (w_cnt >= 2) begin
      check("b2b_first_at", w_at[0], 2 + DEB + 1 + CH - (1 + CH));
      check("b2b_code1", 32'(w_code[0]), 11);
      check("b2b_code2", 32'(w_code[1]), 13);
      check("b2b_spacing", w_at[1] - w_at[0], CH + 1);
    end
    $display("back-to-back events=%0d", w_cnt);
    set_buttons(4'b0000);
    tick(16);

    // Random activity against the model.
    for (int r = 0; r < 80; r++) begin
      set_buttons(4'($urandom_range(0, 15)));
      enable = ($urandom_range(0, 9) != 0);
      tick($urandom_range(1, 14));
    end
    set_buttons(4'b0000);
    enable = 1'b1;
    tick(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
